// File: rtl/nn_result_if.sv
// Result-path bundle between the MLP core, nn_result_buffer and its consumer.
// The slave modport is the buffer side; master is the core/consumer side.
interface nn_result_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic              out0_ready;
  logic              out1_ready;
  logic              res_ready;
  logic              ovf_clr;
  logic              res_valid;
  logic [DATA_W-1:0] res0;
  logic [DATA_W-1:0] res1;
  logic              res_class;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              overflow;
  logic              sync_err;

  modport master (
    output out0, out1, out0_ready, out1_ready, res_ready, ovf_clr,
    input  res_valid, res0, res1, res_class, count, full, overflow, sync_err
  );

  modport slave (
    input  out0, out1, out0_ready, out1_ready, res_ready, ovf_clr,
    output res_valid, res0, res1, res_class, count, full, overflow, sync_err
  );
endinterface

// File: rtl/nn_result_buffer.sv
// FWFT result FIFO with argmax class for the 4-4-2 MLP core; all outputs registered.
// Optional RESULT_RELU_EN clamps negative results to zero before storing.
module nn_result_buffer #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  nn_result_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_W + 1;

  // Entry layout: {class, res1, res0}
  logic [ENT_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  wr_q, rd_q, count_q;
  logic              res_valid_q, full_q, overflow_q, sync_err_q;
  logic [ENT_W-1:0]  head_q;

  logic signed [DATA_W-1:0] in0_v, in1_v;
  logic [ENT_W-1:0]  new_ent_c, head_d;
  logic              push_c, pop_c, wr_en_c, ovf_set_c, sync_set_c;
  logic [CNT_W-1:0]  wr_d, rd_d, cnt_d;
  logic [PTR_W-1:0]  rd_idx_d;

  always_comb begin
    in0_v = bus.out0;
    in1_v = bus.out1;
`ifdef RESULT_RELU_EN
    if (in0_v < 0) in0_v = '0;
    if (in1_v < 0) in1_v = '0;
`endif
    new_ent_c = {(in1_v > in0_v), in1_v, in0_v};

    push_c     = bus.out0_ready & bus.out1_ready;
    sync_set_c = bus.out0_ready ^ bus.out1_ready;
    pop_c      = res_valid_q & bus.res_ready;
    wr_en_c    = push_c & (~full_q | pop_c);
    ovf_set_c  = push_c & full_q & ~pop_c;

    wr_d     = wr_q + CNT_W'(wr_en_c);
    rd_d     = rd_q + CNT_W'(pop_c);
    cnt_d    = wr_d - rd_d;
    rd_idx_d = rd_d[PTR_W-1:0];

    // Next head bypasses memory when it is the slot being written this cycle
    head_d = mem[rd_idx_d];
    if (wr_en_c && (wr_q[PTR_W-1:0] == rd_idx_d)) head_d = new_ent_c;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_q[PTR_W-1:0]] <= new_ent_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      res_valid_q <= 1'b0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= cnt_d;
      full_q      <= (cnt_d == CNT_W'(DEPTH));
      res_valid_q <= (cnt_d != '0);
      if (cnt_d != '0) head_q <= head_d;
      // Set wins over a coincident clear
      overflow_q  <= ovf_set_c  | (overflow_q & ~bus.ovf_clr);
      sync_err_q  <= sync_set_c | (sync_err_q & ~bus.ovf_clr);
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res0      = head_q[DATA_W-1:0];
  assign bus.res1      = head_q[2*DATA_W-1:DATA_W];
  assign bus.res_class = head_q[ENT_W-1];
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.sync_err  = sync_err_q;
endmodule
